// File: rtl/prog_load_ctrl_pkg.sv
// Shared types and constants for the front-panel program loader.
package prog_load_ctrl_pkg;

    // Loader / arbiter ownership states.
    typedef enum logic [2:0] {
        RUN,
        STOP,
        LOAD,
        WRITE,
        RESTART
    } load_state_t;

    // Default program length in bytes.
    localparam int PROG_DEPTH = 32;

endpackage

// File: rtl/prog_load_ctrl_edge_rise.sv
// Rising-edge detector for a synchronised, debounced panel button.
module prog_load_ctrl_edge_rise (
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Previous-cycle copy of the button level, updated every cycle.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/prog_load_ctrl.sv
// Program-load controller: shares the RAM port between CPU and panel loader.
module prog_load_ctrl
    import prog_load_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = PROG_DEPTH
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              load_mode,
    input  logic              enter,
    input  logic              addr_clr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_run,
    output logic              cpu_restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] load_ptr,
    output logic              load_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    load_state_t       state, state_nxt;
    logic [DATA_W-1:0] wdata_q;
    logic              enter_rise;

    prog_load_ctrl_edge_rise u_enter_edge (
        .clk_in (clk_in),
        .reset  (reset),
        .d      (enter),
        .rise   (enter_rise)
    );

    // State register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Load pointer, sticky done flag and latched panel byte.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            load_ptr  <= '0;
            load_done <= 1'b0;
            wdata_q   <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (load_mode) begin
                        if (addr_clr) begin
                            load_ptr  <= '0;
                            load_done <= 1'b0;
                        end else if (enter_rise) begin
                            wdata_q <= sw_data;
                        end
                    end
                end
                WRITE: begin
                    if (load_ptr == LAST_ADDR) begin
                        load_ptr  <= '0;
                        load_done <= 1'b1;
                    end else begin
                        load_ptr <= load_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and RAM port steering; CPU owns the port in RUN and the STOP drain cycle.
    always_comb begin
        state_nxt   = state;
        cpu_run     = 1'b0;
        cpu_gnt     = 1'b0;
        cpu_restart = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = load_ptr;
        mem_wdata   = wdata_q;
        unique case (state)
            RUN: begin
                cpu_run   = 1'b1;
                cpu_gnt   = cpu_req;
                mem_we    = cpu_req & cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                if (load_mode) state_nxt = STOP;
            end
            STOP: begin
                cpu_gnt   = cpu_req;
                mem_we    = cpu_req & cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                state_nxt = LOAD;
            end
            LOAD: begin
                if (!load_mode)                 state_nxt = RESTART;
                else if (!addr_clr && enter_rise) state_nxt = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                state_nxt = load_mode ? LOAD : RESTART;
            end
            RESTART: begin
                cpu_restart = 1'b1;
                state_nxt   = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl with a write scoreboard on the RAM port.
module tb_prog_load_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              load_mode, enter, addr_clr;
    logic [DATA_W-1:0] sw_data;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_run, cpu_restart, mem_we;
    logic [ADDR_W-1:0] mem_addr, load_ptr;
    logic [DATA_W-1:0] mem_wdata;
    logic              load_done;

    int  vectors     = 0;
    int  miscompares = 0;
    int  wr_seen     = 0;
    bit  mon_en      = 1'b0;
    wr_t sb_q[$];

    always #5 clk_in = ~clk_in;

    prog_load_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .load_mode   (load_mode),
        .enter       (enter),
        .addr_clr    (addr_clr),
        .sw_data     (sw_data),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_run     (cpu_run),
        .cpu_restart (cpu_restart),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .load_ptr    (load_ptr),
        .load_done   (load_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; loader writes are popped from the scoreboard at the falling edge.
    task automatic tick();
        wr_t e;
        @(negedge clk_in);
        if (mon_en && mem_we) begin
            wr_seen++;
            vectors++;
            assert (sb_q.size() > 0) else begin
                miscompares++;
                $error("FAIL sb_unexpected_write: observed addr %0h data %0h expected none",
                       mem_addr, mem_wdata);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // One enter press/release in LOAD: edge cycle, WRITE cycle, back in LOAD.
    task automatic load_byte(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        sw_data = d;
        enter   = 1'b1;
        push(a, d);
        tick();
        enter = 1'b0;
        tick();
    endtask

    initial begin
        int w0;
        reset     = 1'b1;
        load_mode = 1'b0;
        enter     = 1'b0;
        addr_clr  = 1'b0;
        sw_data   = '0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 5'd5;
        cpu_wdata = 8'h2A;
        #2;
        chk("rst_mem_we", 32'(mem_we), 1);
        chk("rst_mem_addr", 32'(mem_addr), 5);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h2A);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 1);
        chk("rst_cpu_run", 32'(cpu_run), 1);
        chk("rst_restart", 32'(cpu_restart), 0);
        chk("rst_load_ptr", 32'(load_ptr), 0);
        chk("rst_load_done", 32'(load_done), 0);
        @(posedge clk_in); @(posedge clk_in); #1;
        reset  = 1'b0;
        cpu_we = 1'b0;
        #1;
        chk("run_mem_we_rd", 32'(mem_we), 0);

        // Enter load mode with a CPU read pending.
        load_mode = 1'b1;
        #1;
        chk("run_gnt", 32'(cpu_gnt), 1);
        chk("run_run", 32'(cpu_run), 1);
        tick();
        chk("stop_gnt", 32'(cpu_gnt), 1);
        chk("stop_run", 32'(cpu_run), 0);
        tick();
        chk("load_gnt", 32'(cpu_gnt), 0);
        chk("load_run", 32'(cpu_run), 0);
        chk("load_addr", 32'(mem_addr), 0);
        mon_en = 1'b1;

        // Long enter press gives exactly one write.
        w0      = wr_seen;
        sw_data = 8'h09;
        enter   = 1'b1;
        push(5'd0, 8'h09);
        tick();
        chk("write_we", 32'(mem_we), 1);
        chk("write_addr", 32'(mem_addr), 0);
        chk("write_data", 32'(mem_wdata), 32'h09);
        for (int k = 0; k < 9; k++) tick();
        enter = 1'b0;
        tick();
        chk("hold_one_write", 32'(wr_seen - w0), 1);
        chk("hold_ptr", 32'(load_ptr), 1);

        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        chk("clr_ptr", 32'(load_ptr), 0);

        // Fill the whole program, pointer wraps on the last byte.
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                chk("pre_wrap_done", 32'(load_done), 0);
                chk("pre_wrap_ptr", 32'(load_ptr), DEPTH - 1);
            end
            load_byte(ADDR_W'(i), DATA_W'(i));
        end
        chk("wrap_ptr", 32'(load_ptr), 0);
        chk("wrap_done", 32'(load_done), 1);
        chk("fill_sb_empty", 32'(sb_q.size()), 0);

        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        chk("clr_done", 32'(load_done), 0);

        // load_mode falls during the WRITE cycle.
        sw_data = 8'h55;
        enter   = 1'b1;
        push(5'd0, 8'h55);
        tick();
        load_mode = 1'b0;
        enter     = 1'b0;
        #1;
        chk("fall_write_we", 32'(mem_we), 1);
        tick();
        chk("restart_pulse", 32'(cpu_restart), 1);
        chk("restart_run", 32'(cpu_run), 0);
        chk("restart_gnt", 32'(cpu_gnt), 0);
        tick();
        chk("post_restart", 32'(cpu_restart), 0);
        chk("post_run", 32'(cpu_run), 1);
        chk("post_gnt", 32'(cpu_gnt), 1);
        chk("post_ptr", 32'(load_ptr), 1);

        // Reload to ptr 7, then reset in the middle of that write.
        load_mode = 1'b1;
        tick();
        tick();
        for (int i = 1; i < 7; i++) load_byte(ADDR_W'(i), DATA_W'(8'hA0 + i));
        chk("pre_abort_ptr", 32'(load_ptr), 7);
        sw_data = 8'hEE;
        enter   = 1'b1;
        tick();
        chk("abort_write_we", 32'(mem_we), 1);
        chk("abort_write_addr", 32'(mem_addr), 7);
        mon_en = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("abort_we", 32'(mem_we), 0);
        chk("abort_ptr", 32'(load_ptr), 0);
        chk("abort_run", 32'(cpu_run), 1);
        chk("abort_done", 32'(load_done), 0);
        chk("final_sb_empty", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
